// File: rtl/uart_reg_pkg.sv
// Shared constants for the UART register block: register offsets, CTRL/STATUS/IER bit positions,
// the CTRL register layout and the address decoder.
package uart_reg_pkg;

    localparam int FIFO_DEPTH_DEF = 8;

    localparam logic [11:0] OFF_TXDATA = 12'h000;
    localparam logic [11:0] OFF_RXDATA = 12'h004;
    localparam logic [11:0] OFF_CTRL   = 12'h008;
    localparam logic [11:0] OFF_BAUD   = 12'h00C;
    localparam logic [11:0] OFF_STATUS = 12'h010;
    localparam logic [11:0] OFF_IER    = 12'h014;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_PAR_EN   = 2;
    localparam int CTRL_PAR_ODD  = 3;
    localparam int CTRL_STOP2    = 4;
    localparam int CTRL_W        = 5;

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVF     = 4;
    localparam int ST_TX_OVF     = 5;
    localparam int ST_TX_BUSY    = 6;
    localparam int ST_W          = 7;

    localparam int IER_RX_NE     = 0;
    localparam int IER_TX_EMPTY  = 1;
    localparam int IER_OVF       = 2;
    localparam int IER_W         = 3;

    typedef struct packed {
        logic stop2;
        logic parity_odd;
        logic parity_en;
        logic rx_en;
        logic tx_en;
    } ctrl_t;

    // Misaligned addresses never match an offset, so they fall out as illegal here too.
    function automatic logic addr_legal(input logic [11:0] a, input logic wr, input logic has_ier);
        case (a)
            OFF_TXDATA, OFF_CTRL, OFF_BAUD, OFF_STATUS: return 1'b1;
            OFF_RXDATA: return !wr;
            OFF_IER:    return has_ier;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_reg_fifo.sv
// 8-bit synchronous FIFO with wrap-bit pointers. A push into a full FIFO only lands
// when a pop happens in the same cycle; otherwise the byte is dropped and reported.
module uart_reg_fifo
    import uart_reg_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wptr, rptr;
    logic [7:0]  mem [DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign drop    = push & full & !do_pop;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_reg_block.sv
// APB-side register block for a UART: TX/RX byte FIFOs, CTRL/BAUD/STATUS registers.
// Define UART_REG_IRQ_EN to add the IER register at 0x014 and a registered irq output.
module uart_reg_block
    import uart_reg_pkg::*;
#(
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [15:0] BAUD_RST   = 16'h001B
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic        pready,
    input  logic [11:0] waddr,
    input  logic [11:0] raddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        wadderr,
    output logic        radderr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        tx_en,
    output logic        rx_en,
    output logic        parity_en,
    output logic        parity_odd,
    output logic        stop2,
    output logic [15:0] baud_div,
    input  logic        tx_busy,
    output logic        irq
);

`ifdef UART_REG_IRQ_EN
    localparam logic HAS_IER = 1'b1;
`else
    localparam logic HAS_IER = 1'b0;
`endif

    logic              access, wlegal, rlegal, wr_done, rd_done;
    logic              w1c;
    ctrl_t             ctrl;
    logic [15:0]       baud;
    logic              tx_ovf, rx_ovf;
    logic              tx_empty, tx_full, tx_drop, tx_pop;
    logic              rx_empty, rx_full, rx_drop, rx_pop, rx_push;
    logic [7:0]        rx_head;
    logic              tx_push;
    logic [ST_W-1:0]   status;
    logic [IER_W-1:0]  ier_rd;
    logic              unused_wdata;

    // Bus side effects are qualified by the completion cycle and a legal address only.
    assign access  = psel & penable;
    assign wlegal  = addr_legal(waddr, 1'b1, HAS_IER);
    assign rlegal  = addr_legal(raddr, 1'b0, HAS_IER);
    assign wr_done = access & pready & pwrite & wlegal;
    assign rd_done = access & pready & !pwrite & rlegal;
    assign wadderr = !(access & pwrite & !wlegal);
    assign radderr = !(access & !pwrite & !rlegal);
    assign w1c     = wr_done && (waddr == OFF_STATUS);

    assign unused_wdata = &{1'b0, wdata[31:16]};

    assign tx_push  = wr_done && (waddr == OFF_TXDATA);
    assign tx_valid = ctrl.tx_en & !tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & ctrl.rx_en;
    assign rx_pop   = rd_done && (raddr == OFF_RXDATA);

    uart_reg_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .pclk   (pclk),
        .preset (preset),
        .push   (tx_push),
        .din    (wdata[7:0]),
        .pop    (tx_pop),
        .dout   (tx_data),
        .empty  (tx_empty),
        .full   (tx_full),
        .drop   (tx_drop)
    );

    uart_reg_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .pclk   (pclk),
        .preset (preset),
        .push   (rx_push),
        .din    (rx_data),
        .pop    (rx_pop),
        .dout   (rx_head),
        .empty  (rx_empty),
        .full   (rx_full),
        .drop   (rx_drop)
    );

    // Sticky overflow flags: a new overflow in the clearing cycle keeps the flag set.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ctrl   <= '0;
            baud   <= BAUD_RST;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (wr_done && (waddr == OFF_CTRL)) ctrl <= ctrl_t'(wdata[CTRL_W-1:0]);
            if (wr_done && (waddr == OFF_BAUD)) baud <= wdata[15:0];
            if (tx_drop)                        tx_ovf <= 1'b1;
            else if (w1c && wdata[ST_TX_OVF])   tx_ovf <= 1'b0;
            if (rx_drop)                        rx_ovf <= 1'b1;
            else if (w1c && wdata[ST_RX_OVF])   rx_ovf <= 1'b0;
        end
    end

    assign status     = {tx_busy, tx_ovf, rx_ovf, rx_full, rx_empty, tx_full, tx_empty};
    assign tx_en      = ctrl.tx_en;
    assign rx_en      = ctrl.rx_en;
    assign parity_en  = ctrl.parity_en;
    assign parity_odd = ctrl.parity_odd;
    assign stop2      = ctrl.stop2;
    assign baud_div   = baud;

`ifdef UART_REG_IRQ_EN
    logic [IER_W-1:0] ier;
    logic [IER_W-1:0] irq_src;
    logic             irq_r;

    assign irq_src = {tx_ovf | rx_ovf, tx_empty, !rx_empty};

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ier   <= '0;
            irq_r <= 1'b0;
        end else begin
            if (wr_done && (waddr == OFF_IER)) ier <= wdata[IER_W-1:0];
            irq_r <= |(ier & irq_src);
        end
    end

    assign irq    = irq_r;
    assign ier_rd = ier;
`else
    assign irq    = 1'b0;
    assign ier_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        if (rlegal) begin
            case (raddr)
                OFF_RXDATA: rdata = {24'h0, rx_empty ? 8'h00 : rx_head};
                OFF_CTRL:   rdata = {27'h0, ctrl};
                OFF_BAUD:   rdata = {16'h0, baud};
                OFF_STATUS: rdata = {25'h0, status};
                OFF_IER:    rdata = {29'h0, ier_rd};
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_block.sv
// Directed bench for uart_reg_block with byte scoreboards for the TX and RX paths.
// Also covers the UART_REG_IRQ_EN build when compiled with that macro.
module tb_uart_reg_block;
    import uart_reg_pkg::*;

    logic        pclk = 1'b0;
    logic        preset, psel, penable, pwrite, pready;
    logic [11:0] waddr, raddr;
    logic [31:0] wdata, rdata;
    logic        wadderr, radderr;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_en, rx_en, parity_en, parity_odd, stop2;
    logic [15:0] baud_div;
    logic        tx_busy, irq;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    bit          inj_rx = 1'b0;
    logic [7:0]  inj_byte = 8'h00;

    uart_reg_block dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pready(pready), .waddr(waddr), .raddr(raddr), .wdata(wdata), .rdata(rdata),
        .wadderr(wadderr), .radderr(radderr), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .tx_en(tx_en),
        .rx_en(rx_en), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .baud_div(baud_div), .tx_busy(tx_busy), .irq(irq)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One APB transfer; 'waits' stalls the access phase. Sampled #1 into the completion cycle.
    task automatic apb_xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                            input int waits, output logic [31:0] rd, output logic err);
        @(negedge pclk);
        psel = 1'b1; pwrite = wr; penable = 1'b0; pready = 1'b0;
        waddr = addr; raddr = addr; wdata = wd;
        @(negedge pclk);
        penable = 1'b1;
        repeat (waits) @(negedge pclk);
        pready = 1'b1;
        rx_valid = inj_rx; rx_data = inj_byte;
        #1;
        rd  = rdata;
        err = wr ? wadderr : radderr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pready = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] wd, input string tag);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b1, addr, wd, 0, rd, err);
        chk({tag, "_wadderr"}, err, 1);
    endtask

    task automatic wr_bad(input logic [11:0] addr, input logic [31:0] wd, input string tag);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b1, addr, wd, 0, rd, err);
        chk({tag, "_wadderr"}, err, 0);
    endtask

    task automatic rd_chk(input logic [11:0] addr, input logic [31:0] exp, input int waits,
                          input string tag);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b0, addr, 32'h0, waits, rd, err);
        chk(tag, rd, exp);
        chk({tag, "_radderr"}, err, 1);
    endtask

    task automatic rd_bad(input logic [11:0] addr, input string tag);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b0, addr, 32'h0, 0, rd, err);
        chk(tag, rd, 0);
        chk({tag, "_radderr"}, err, 0);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge pclk);
        rx_valid = 1'b1; rx_data = b;
        @(negedge pclk);
        rx_valid = 1'b0;
    endtask

    // Entered at a negedge; every accepted byte is compared against the TX scoreboard.
    task automatic drain_tx(input string tag);
        logic [7:0] e;
        int         n;
        n = 0;
        tx_ready = 1'b1;
        while (txq.size() != 0 && n < 100) begin
            #1;
            if (tx_valid) begin
                e = txq.pop_front();
                chk(tag, tx_data, e);
            end
            @(negedge pclk);
            n++;
        end
        chk({tag, "_left"}, txq.size(), 0);
        tx_ready = 1'b0;
    endtask

    task automatic drain_rx(input string tag);
        logic [7:0] e;
        while (rxq.size() != 0) begin
            e = rxq.pop_front();
            rd_chk(OFF_RXDATA, {24'h0, e}, 0, tag);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_irq"}, irq, 0);
        chk({tag, "_wadderr"}, wadderr, 1);
        chk({tag, "_radderr"}, radderr, 1);
        chk({tag, "_baud"}, baud_div, 32'h001B);
        chk({tag, "_ctrl"}, {stop2, parity_odd, parity_en, rx_en, tx_en}, 0);
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pready = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; tx_ready = 1'b0; rx_data = '0;
        rx_valid = 1'b0; tx_busy = 1'b0;
        repeat (3) @(negedge pclk);
        check_reset("rst_hold");
        preset = 1'b0;
        @(negedge pclk);
        check_reset("rst_rel");
        rd_chk(OFF_STATUS, 32'h05, 0, "status_rst");
        rd_chk(OFF_BAUD, 32'h1B, 0, "baud_rst");
        rd_chk(OFF_TXDATA, 32'h0, 0, "txdata_reads0");

        // Basic TX stream: bytes leave in write order.
        wr(OFF_CTRL, 32'h01, "ctrl_txen");
        wr(OFF_TXDATA, 32'hFFFF_FF41, "tx41"); txq.push_back(8'h41);
        wr(OFF_TXDATA, 32'h0000_0042, "tx42"); txq.push_back(8'h42);
        chk("tx_valid_pending", tx_valid, 1);
        drain_tx("tx_basic");
        chk("tx_valid_idle", tx_valid, 0);
        rd_chk(OFF_STATUS, 32'h05, 0, "status_tx_empty");

        // TX overflow: ninth byte dropped; tx_ovf|rx_empty|tx_full.
        wr(OFF_CTRL, 32'h00, "ctrl_off");
        for (int i = 0; i < 9; i++) begin
            wr(OFF_TXDATA, 32'h10 + i, "tx_fill");
            if (i < 8) txq.push_back(8'(8'h10 + i));
        end
        rd_chk(OFF_STATUS, 32'h26, 0, "status_tx_ovf");
        wr(OFF_STATUS, 32'h20, "w1c_tx_ovf");
        rd_chk(OFF_STATUS, 32'h06, 0, "status_tx_ovf_clr");
        wr(OFF_CTRL, 32'h01, "ctrl_txen2");
        drain_tx("tx_wrap");
        rd_chk(OFF_STATUS, 32'h05, 0, "status_tx_drained");

        // CTRL / BAUD fields and pins.
        wr(OFF_CTRL, 32'hFFFF_FFFF, "ctrl_all");
        rd_chk(OFF_CTRL, 32'h1F, 0, "ctrl_rd");
        chk("ctrl_pins", {stop2, parity_odd, parity_en, rx_en, tx_en}, 32'h1F);
        wr(OFF_BAUD, 32'hABCD_1234, "baud_wr");
        rd_chk(OFF_BAUD, 32'h1234, 0, "baud_rd");
        chk("baud_pin", baud_div, 32'h1234);
        wr(OFF_CTRL, 32'h03, "ctrl_txrx");
        tx_busy = 1'b1;
        rd_chk(OFF_STATUS, 32'h45, 0, "status_busy");
        tx_busy = 1'b0;

        // RX with a stalled read: only one pop per transfer.
        rx_pulse(8'h5A); rxq.push_back(8'h5A);
        rx_pulse(8'h5B); rxq.push_back(8'h5B);
        rd_chk(OFF_RXDATA, {24'h0, rxq.pop_front()}, 1, "rx_wait_rd");
        rd_chk(OFF_RXDATA, {24'h0, rxq.pop_front()}, 0, "rx_second");
        rd_chk(OFF_STATUS, 32'h05, 0, "status_rx_empty");
        rd_chk(OFF_RXDATA, 32'h0, 0, "rx_empty_rd");

        // Illegal accesses.
        rd_bad(12'h006, "rd_misaligned");
        rd_bad(12'h020, "rd_unmapped");
        wr_bad(OFF_RXDATA, 32'h55, "wr_rxdata");
        wr_bad(12'h00A, 32'h00, "wr_misaligned");
        rd_chk(OFF_CTRL, 32'h03, 0, "ctrl_untouched");
        rd_chk(OFF_STATUS, 32'h05, 0, "status_untouched");
`ifndef UART_REG_IRQ_EN
        wr_bad(OFF_IER, 32'h7, "wr_ier_absent");
        rd_bad(OFF_IER, "rd_ier_absent");
`endif

        // rx_en=0 ignores incoming bytes.
        wr(OFF_CTRL, 32'h01, "ctrl_rx_off");
        rx_pulse(8'h77);
        rd_chk(OFF_STATUS, 32'h05, 0, "rx_disabled");
        wr(OFF_CTRL, 32'h03, "ctrl_rx_on");

        // RX full, overflow, W1C collision, then push+pop on full.
        for (int i = 0; i < 8; i++) begin
            rx_pulse(8'(8'h80 + i));
            rxq.push_back(8'(8'h80 + i));
        end
        rd_chk(OFF_STATUS, 32'h09, 0, "status_rx_full");
        rx_pulse(8'hEE);
        rd_chk(OFF_STATUS, 32'h19, 0, "status_rx_ovf");
        inj_rx = 1'b1; inj_byte = 8'hEE;
        wr(OFF_STATUS, 32'h10, "w1c_collide");
        inj_rx = 1'b0;
        rd_chk(OFF_STATUS, 32'h19, 0, "sticky_set_wins");
        wr(OFF_STATUS, 32'h10, "w1c_rx_ovf");
        rd_chk(OFF_STATUS, 32'h09, 0, "status_rx_ovf_clr");
        inj_rx = 1'b1; inj_byte = 8'hC3;
        rd_chk(OFF_RXDATA, {24'h0, rxq.pop_front()}, 0, "rx_full_pushpop");
        rxq.push_back(8'hC3);
        inj_rx = 1'b0;
        rd_chk(OFF_STATUS, 32'h09, 0, "status_full_no_ovf");
        drain_rx("rx_drain");
        rd_chk(OFF_STATUS, 32'h05, 0, "status_rx_drained");

`ifdef UART_REG_IRQ_EN
        wr(OFF_IER, 32'h1, "ier_wr");
        rd_chk(OFF_IER, 32'h1, 0, "ier_rd");
        chk("irq_idle", irq, 0);
        rx_pulse(8'h33);
        chk("irq_latency", irq, 0);
        @(negedge pclk);
        chk("irq_set", irq, 1);
        rd_chk(OFF_RXDATA, 32'h33, 0, "irq_pop");
        @(negedge pclk);
        chk("irq_clear", irq, 0);
`else
        rx_pulse(8'h33);
        @(negedge pclk);
        chk("irq_tied", irq, 0);
        rd_chk(OFF_RXDATA, 32'h33, 0, "rx_pop_noirq");
`endif

        // Reset landing on a TXDATA completion cycle with both FIFOs loaded.
        wr(OFF_CTRL, 32'h02, "ctrl_burst");
        wr(OFF_TXDATA, 32'h61, "burst_tx0");
        wr(OFF_TXDATA, 32'h62, "burst_tx1");
        rx_pulse(8'h71);
        rx_pulse(8'h72);
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b1; waddr = OFF_TXDATA; wdata = 32'h99;
        @(negedge pclk);
        penable = 1'b1; pready = 1'b1; preset = 1'b1;
        @(negedge pclk);
        check_reset("rst_mid");
        raddr = OFF_STATUS;
        #1 chk("rst_mid_status", rdata, 32'h05);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pready = 1'b0; preset = 1'b0;
        txq.delete(); rxq.delete();
        rd_chk(OFF_CTRL, 32'h0, 0, "post_rst_ctrl");
        rd_chk(OFF_BAUD, 32'h1B, 0, "post_rst_baud");
`ifdef UART_REG_IRQ_EN
        rd_chk(OFF_IER, 32'h0, 0, "post_rst_ier");
`endif
        wr(OFF_CTRL, 32'h01, "post_rst_txen");
        chk("post_rst_no_push", tx_valid, 0);
        rd_chk(OFF_RXDATA, 32'h0, 0, "post_rst_rx_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
